// File: rtl/data_mem_pkg.sv
// Shared types and constants for the per-thread data-memory responder.
package data_mem_pkg;

  localparam int unsigned STATE_BITS         = 2;
  localparam int unsigned MIN_ACCESS_LATENCY = 1;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } resp_state_e;

endpackage

// File: rtl/data_mem_responder_arbiter.sv
// Combinational round-robin picker: first eligible lane at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  localparam int unsigned IDX_W = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1
) (
  input  logic [THREADS_PER_BLOCK-1:0] i_eligible,
  input  logic [IDX_W-1:0]             i_rr_ptr,
  output logic                         o_grant_valid_c,
  output logic [IDX_W-1:0]             o_grant_index_c
);

  int unsigned v_idx;

  // Scan upward from the pointer; the first hit wins.
  always_comb begin
    o_grant_valid_c = 1'b0;
    o_grant_index_c = '0;
    v_idx           = 0;
    for (int unsigned k = 0; k < THREADS_PER_BLOCK; k++) begin
      v_idx = (32'(i_rr_ptr) + k) % THREADS_PER_BLOCK;
      if (!o_grant_valid_c && i_eligible[IDX_W'(v_idx)]) begin
        o_grant_valid_c = 1'b1;
        o_grant_index_c = IDX_W'(v_idx);
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the per-thread data-memory protocol: round-robin grant,
// fixed access latency, single-port storage, one-cycle ready pulses.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_MEM_ADDR_BITS = 8,
  parameter int unsigned DATA_MEM_DATA_BITS = 8,
  parameter int unsigned THREADS_PER_BLOCK  = 4,
  parameter int unsigned ACCESS_LATENCY     = 2
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [THREADS_PER_BLOCK-1:0]                         read_valid,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_ADDR_BITS-1:0] read_address,
  output logic [THREADS_PER_BLOCK-1:0]                         read_ready,
  output logic [THREADS_PER_BLOCK-1:0][DATA_MEM_DATA_BITS-1:0] read_data,
  input  logic [THREADS_PER_BLOCK-1:0]                         write_valid,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_ADDR_BITS-1:0] write_address,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_DATA_BITS-1:0] write_data,
  output logic [THREADS_PER_BLOCK-1:0]                         write_ready
);

  localparam int unsigned AW    = DATA_MEM_ADDR_BITS;
  localparam int unsigned DW    = DATA_MEM_DATA_BITS;
  localparam int unsigned NT    = THREADS_PER_BLOCK;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned IDX_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int unsigned LAT   = (ACCESS_LATENCY < MIN_ACCESS_LATENCY) ?
                                  MIN_ACCESS_LATENCY : ACCESS_LATENCY;
  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  resp_state_e      r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [NT-1:0]    r_served;
  logic [IDX_W-1:0] r_lane;
  logic             r_do_rd;
  logic             r_do_wr;
  logic [AW-1:0]    r_raddr;
  logic [AW-1:0]    r_waddr;
  logic [DW-1:0]    r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_mem [DEPTH];

  logic [NT-1:0]    w_eligible;
  logic             w_grant_valid;
  logic [IDX_W-1:0] w_grant_index;
  logic [IDX_W-1:0] w_rr_next;
  logic             w_commit;
  logic [DW-1:0]    w_rd_word;
  logic [NT-1:0]    w_served_next;

  assign w_eligible = (read_valid | write_valid) & ~r_served;
  assign w_rr_next  = (w_grant_index == IDX_W'(NT - 1)) ? '0 : w_grant_index + IDX_W'(1);
  assign w_commit   = (r_state == ST_ACCESS) && (r_cnt == '0);
  // Write-first: a combined read of the address being written returns the new word.
  assign w_rd_word  = (r_do_wr && (r_waddr == r_raddr)) ? r_wdata : r_mem[r_raddr];

  rr_arbiter #(
    .THREADS_PER_BLOCK(NT)
  ) u_arb (
    .i_eligible      (w_eligible),
    .i_rr_ptr        (r_rr_ptr),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_index_c (w_grant_index)
  );

  // Served flags drop once a lane releases both valids; a commit re-arms its lane.
  always_comb begin
    w_served_next = r_served & (read_valid | write_valid);
    if (w_commit) begin
      w_served_next[r_lane] = 1'b1;
    end
  end

  // Storage is deliberately not reset; an abandoned access never reaches here.
  always_ff @(posedge clk) begin
    if (w_commit && r_do_wr && !reset) begin
      r_mem[r_waddr] <= r_wdata;
    end
  end

  // Responder FSM: grant in IDLE, count down in ACCESS, drop ready in RESPOND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_served    <= '0;
      r_lane      <= '0;
      r_do_rd     <= 1'b0;
      r_do_wr     <= 1'b0;
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      read_ready  <= '0;
      write_ready <= '0;
      read_data   <= '0;
    end else begin
      r_served <= w_served_next;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_lane   <= w_grant_index;
            r_do_rd  <= read_valid[w_grant_index];
            r_do_wr  <= write_valid[w_grant_index];
            r_raddr  <= read_address[w_grant_index];
            r_waddr  <= write_address[w_grant_index];
            r_wdata  <= write_data[w_grant_index];
            r_cnt    <= CNT_W'(LAT - 1);
            r_rr_ptr <= w_rr_next;
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            if (r_do_rd) begin
              read_data[r_lane]  <= w_rd_word;
              read_ready[r_lane] <= 1'b1;
            end
            if (r_do_wr) begin
              write_ready[r_lane] <= 1'b1;
            end
            r_state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          read_ready  <= '0;
          write_ready <= '0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
